// File: rtl/mp_reg_file.sv
// Multi-port register file with hardwired zero register, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rd_en/rd_addr           per-port read enable and address (port i at [i*AW +: AW])
//   rd_data/rd_busy         combinational read data and busy bit per read port
//   wr_en/wr_addr/wr_data   per-port write-back; the highest port index wins on conflict
//   claim_en/claim_addr     issue-side claim of a destination register
//   busy_vec                full scoreboard, bit r = register r pending
module mp_reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 1,
    parameter bit          BYPASS     = 1'b1,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_READ-1:0]             rd_en,
    input  logic [NUM_READ*AW-1:0]          rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*AW-1:0]         wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    input  logic                            claim_en,
    input  logic [AW-1:0]                   claim_addr,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;

    // True when any write port targets the given address this cycle.
    function automatic logic wr_hit(input logic [AW-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Register array; later ports overwrite earlier ones, so the highest index wins.
    // Entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) mem[r] <= '0;
            busy <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            busy <= busy_nxt;
        end
    end

    // Scoreboard next state: a claim beats a simultaneous write-back.
    always_comb begin
        busy_nxt = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (claim_en && (claim_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_hit(AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end else begin
                busy_nxt[r] = busy[r];
            end
        end
    end

    // Combinational read ports with optional bypass from this cycle's writes.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            if (rd_en[i] && (rd_addr[i*AW +: AW] != '0)) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[i*AW +: AW]];
                rd_busy[i] = busy[rd_addr[i*AW +: AW]];
                if (BYPASS) begin
                    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                            rd_busy[i] = claim_en && (claim_addr == rd_addr[i*AW +: AW]);
                        end
                    end
                end
            end
        end
    end

    assign busy_vec = busy;

endmodule
